// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential multiplier: state encoding and default width.
package seq_multiplier_pkg;

  localparam int unsigned SEQ_MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mult_state_t;

endpackage

// File: rtl/adder_nbit.sv
// WIDTH-bit ripple-carry adder with carry-out: a half-adder cell at bit 0, full-adder cells above.
module adder_nbit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i == 0) begin : g_half
      assign o_sum[i]   = i_a[i] ^ i_b[i];
      assign w_c[i + 1] = i_a[i] & i_b[i];
    end else begin : g_full
      assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign w_c[0]  = 1'b0;
  assign o_cout  = w_c[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier (MULT/MULTU): one add/shift step per RUN cycle on operand magnitudes,
// sign applied to the 2*WIDTH-bit product in FINISH.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_MULT_WIDTH
) (
  input  logic             CLK_in,
  input  logic             RST_in,
  input  logic             START_in,
  input  logic             SIGNED_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             BUSY_out,
  output logic             DONE_out,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out
);

  localparam int unsigned CW = $clog2(WIDTH);

  // Two's-complement negation as invert plus a half-adder increment chain.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    logic             c;
    c = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = ~x[i] ^ c;
      c    = ~x[i] & c;
    end
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    logic [2*WIDTH-1:0] r;
    logic               c;
    c = 1'b1;
    for (int unsigned i = 0; i < 2*WIDTH; i++) begin
      r[i] = ~x[i] ^ c;
      c    = ~x[i] & c;
    end
    return r;
  endfunction

  mult_state_t        r_state, w_next;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_mcand, r_acc, r_mplier;
  logic               r_neg, r_done;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_sum, w_step_acc;
  logic               w_cout, w_step_c;
  logic [2*WIDTH-1:0] w_prod, w_result;

  adder_nbit #(.WIDTH(WIDTH)) u_adder (
    .i_a    (r_acc),
    .i_b    (r_mcand),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_a_mag    = (SIGNED_in && A_in[WIDTH-1]) ? neg_w(A_in) : A_in;
    w_b_mag    = (SIGNED_in && B_in[WIDTH-1]) ? neg_w(B_in) : B_in;
    w_step_c   = r_mplier[0] & w_cout;
    w_step_acc = r_mplier[0] ? w_sum : r_acc;
    w_prod     = {r_acc, r_mplier};
    w_result   = r_neg ? neg_2w(w_prod) : w_prod;
  end

  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    BUSY_out = 1'b1;
    case (r_state)
      IDLE: begin
        BUSY_out = 1'b0;
        if (START_in) w_next = RUN;
      end
      RUN:     if (r_count == CW'(WIDTH - 1)) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      r_count  <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (START_in) begin
          r_mcand  <= w_a_mag;
          r_mplier <= w_b_mag;
          r_acc    <= '0;
          r_count  <= '0;
          r_neg    <= SIGNED_in & (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
        end
        RUN: begin
          // {carry, acc, multiplier} >> 1, with the step's carry-out entering at the top
          r_acc    <= {w_step_c, w_step_acc[WIDTH-1:1]};
          r_mplier <= {w_step_acc[0], r_mplier[WIDTH-1:1]};
          r_count  <= r_count + CW'(1);
        end
        FINISH: begin
          r_hi   <= w_result[2*WIDTH-1:WIDTH];
          r_lo   <= w_result[WIDTH-1:0];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign DONE_out = r_done;
  assign HI_out   = r_hi;
  assign LO_out   = r_lo;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed operations push expected {HI,LO,done-cycle}; a monitor pops on DONE.
module tb_seq_multiplier;

  localparam int unsigned W = 32;

  logic        clk = 1'b0;
  logic        rst, start, sgn;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] at;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .CLK_in    (clk),
    .RST_in    (rst),
    .START_in  (start),
    .SIGNED_in (sgn),
    .A_in      (a),
    .B_in      (b),
    .BUSY_out  (busy),
    .DONE_out  (done),
    .HI_out    (hi),
    .LO_out    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest pending expectation, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got DONE=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("result", {hi, lo}, {e.hi, e.lo});
          check("done_cycle", 64'(cyc), 64'(e.at));
        end
      end
    end
  end

  // Called at a negedge; START is sampled at the following posedge (edge N), DONE expected in cycle N+W+1.
  task automatic issue(input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eh, input logic [31:0] el, input bit expect_done);
    exp_t e;
    int   k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("idle_before_start", 64'(busy), 64'(0));
    start = 1'b1;
    sgn   = s;
    a     = av;
    b     = bv;
    if (expect_done) begin
      e.hi = eh;
      e.lo = el;
      e.at = cyc + W + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    a   = $urandom;
    b   = $urandom;
    sgn = ~s;
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", 64'(sb.size()), 64'(0));
  endtask

  task automatic hold(input int n, input logic [31:0] eh, input logic [31:0] el);
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      b = $urandom;
      sgn = 1'($urandom);
      @(negedge clk);
      check("hold", {hi, lo}, {eh, el});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {28'd0, busy, done, 34'd0}, 64'd0);
    check("reset_result", {hi, lo}, 64'd0);
    rst = 1'b0;

    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
    issue(1'b1, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);

    issue(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignores_start", 64'(busy), 64'(1));
    drain();

    issue(1'b0, 32'h00001234, 32'h00000010, 32'd0, 32'd0, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_reset_flags", {busy, done}, 64'd0);
    check("midrun_reset_result", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1);

    issue(1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1);
    issue(1'b1, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b1);
    issue(1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b1);
    issue(1'b1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    issue(1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1);
    issue(1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    drain();
    hold(20, 32'hFFFFFFFF, 32'h80000000);

    issue(1'b1, 32'h00000000, 32'hFFFFFFFB, 32'd0, 32'd0, 1'b1);
    issue(1'b0, 32'h00000000, 32'h12345678, 32'd0, 32'd0, 1'b1);
    drain();
    hold(100, 32'd0, 32'd0);

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand width in bits; legal values are 8 to 32 inclusive.
REQ-002 SHALL have port CLK_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_in, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port START_in, input, 1 bit: request to begin a multiply.
REQ-005 SHALL have port SIGNED_in, input, 1 bit: 1 selects MULT (two's complement), 0 selects MULTU.
REQ-006 SHALL have port A_in, input, WIDTH bits: multiplicand.
REQ-007 SHALL have port B_in, input, WIDTH bits: multiplier.
REQ-008 SHALL have port BUSY_out, output, 1 bit: high while a multiply is in progress.
REQ-009 SHALL have port DONE_out, output, 1 bit: one-cycle pulse when the result registers update.
REQ-010 SHALL have port HI_out, output, WIDTH bits: upper half of the 2*WIDTH-bit product.
REQ-011 SHALL have port LO_out, output, WIDTH bits: lower half of the 2*WIDTH-bit product.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and FINISH.
REQ-013 SHALL make these transitions:
- IDLE to RUN on START_in=1.
- RUN to FINISH after exactly WIDTH RUN cycles.
- FINISH to IDLE unconditionally.
REQ-014 SHALL, on accepting START_in in IDLE, capture A_in, B_in and SIGNED_in; later input changes SHALL NOT affect the operation in flight.
REQ-015 SHALL ignore START_in in RUN and FINISH; requests are not queued.
REQ-016 SHALL drive BUSY_out=1 in RUN and FINISH, and 0 in IDLE.
REQ-017 SHALL execute one shift-add step per RUN cycle on the operand magnitudes:
- if the multiplier LSB is 1, add the multiplicand magnitude to the upper accumulator, with carry-out kept;
- then shift the {carry, accumulator, multiplier} register right by one bit.
REQ-018 SHALL, in signed mode, take the magnitude of each negative operand by two's-complement negation.
- -2^(WIDTH-1) SHALL be treated as magnitude 2^(WIDTH-1), unsigned.
REQ-019 SHALL, in FINISH, negate the 2*WIDTH-bit product if signed mode is selected and the operand signs differ.
- The result SHALL be written to HI_out/LO_out in the same edge as the DONE_out pulse.
REQ-020 SHALL give a fixed latency: START_in accepted at edge N gives DONE_out=1 during cycle N+WIDTH+1, with HI_out/LO_out valid from that cycle.
REQ-021 SHALL change HI_out/LO_out only at FINISH; they hold the last result indefinitely.
REQ-022 SHALL produce an exact 2*WIDTH-bit product with no overflow; a zero operand yields HI=LO=0.

Reset
REQ-023 SHALL, on RST_in=1 at any time including mid-RUN, return asynchronously to this state:
- FSM in IDLE;
- BUSY_out=0 and DONE_out=0;
- HI_out=0 and LO_out=0;
- internal accumulators cleared;
- any in-flight operation discarded with no DONE_out pulse.
REQ-024 SHALL accept START_in on the first rising edge after RST_in deasserts.

Structure
REQ-025 SHALL place the following in the shared CPU package:
- the FSM state encoding (IDLE, RUN, FINISH);
- the WIDTH default constant.
REQ-026 SHALL instantiate exactly one sub-module, adder_nbit: a WIDTH-bit ripple-carry adder with carry-out, built from the codebase's existing half/full adder cells, used for the step add.
REQ-027 SHALL implement product negation with the same two's-complement method, not a behavioural "-" operator.

Verification
REQ-028 SHALL cover unsigned max: SIGNED=0, A=B=0xFFFFFFFF -> after 33 cycles DONE pulse, HI=0xFFFFFFFE, LO=0x00000001.
REQ-029 SHALL cover signed mixed signs: SIGNED=1, A=0xFFFFFFFF (-1), B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFF9.
REQ-030 SHALL cover the signed minimum: SIGNED=1, A=B=0x80000000 -> HI=0x40000000, LO=0x00000000; and A=0x80000000, B=1 -> HI=0xFFFFFFFF, LO=0x80000000.
REQ-031 SHALL cover START while busy: START at cycle 0 (3x5), START again at cycle 10 (9x9) -> exactly one DONE at cycle 33 with LO=15; the second request is ignored.
REQ-032 SHALL cover reset mid-RUN: RST pulse at cycle 12 -> BUSY=0 immediately, HI=LO=0, no DONE; a new START after reset completes normally.
REQ-033 SHALL cover zero and hold: A=0, B=0x12345678 -> HI=LO=0; outputs then hold unchanged for 100 idle cycles with random A/B toggling.
